seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, registered ALU with a start/done handshake; the successor to the combinational 16-bit ALU. It keeps that ALU's opcode map and z/n/c/v flag set and adds carry-chained add/subtract, arithmetic shift and rotate. It also adds iterative multiply and divide through a multi-cycle state machine. It sits between the register file and the writeback stage, which waits on `done` before committing `y`, `r` and the flags.

## Interface
- `WIDTH`, 16, operand and result width, ≥4.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `ALUop`  in  5  opcode, captured on accept.
- `A`  in  WIDTH  operand A, captured on accept.
- `B`  in  WIDTH  operand B, captured on accept.
- `Ext_cin`  in  1  carry-in for ADC/SBC, captured on accept.
- `busy`  out  1  high from the cycle after accept until the cycle `done` rises.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `y`  out  WIDTH  primary result.
- `r`  out  WIDTH  secondary result: MUL high half or DIV remainder; 0 for all other ops.
- `z`, `n`, `c`, `v`  out  1 each  flags.

## Operation
- Opcodes:
  - 00000 ADD: A+B.
  - 00001 ADC: A+B+Ext_cin.
  - 00010 SUB: A−B.
  - 00011 SBC: A−B−(~Ext_cin).
  - 00100 AND.
  - 00101 OR.
  - 00110 XOR.
  - 00111 NOT: ~A.
  - 01000 LSL: A<<1.
  - 01001 LSR: A>>1.
  - 01010 ASR: arithmetic A>>1.
  - 01011 ROR: rotate A right by 1.
  - 01100 MUL: unsigned A×B; low half in `y`, high half in `r`.
  - 01101 DIV: unsigned A÷B; quotient in `y`, remainder in `r`.
  - Any other code is illegal.
- `z` = (`y`==0). `n` = `y`[WIDTH-1]. Both are set for every op.
- `c`:
  - ADD/ADC: carry out of bit WIDTH-1.
  - SUB/SBC: 1 = no borrow (A ≥ B+borrow, unsigned).
  - LSL: bit shifted out, A[WIDTH-1].
  - LSR/ASR/ROR: A[0].
  - MUL: 1 when `r`≠0.
  - All other ops: 0.
- `v`:
  - ADD/ADC/SUB/SBC: two's-complement signed overflow.
  - DIV: 1 on divide-by-zero.
  - All other ops: 0.
- DIV by zero: `y` = all ones, `r` = A, `v`=1, `c`=0. Completes in the single-cycle latency; no iteration.
- Illegal opcode: `y`=0, `r`=0, `z`=1, `n`=`c`=`v`=0, single-cycle latency.
- States:
  - IDLE: on accept, single-cycle ops go to FIN; MUL, and DIV with B≠0, go to ITER with counter=0.
  - ITER: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. Go to FIN when counter reaches WIDTH-1.
  - FIN: write `y`/`r`/flags, pulse `done`, return to IDLE.
- Operand changes after accept have no effect. `start` while `busy`=1 is ignored, with no queueing.

## Timing
- Reset (async assert, any state): state=IDLE; `y`=`r`=0; `z`=`n`=`c`=`v`=0; `busy`=`done`=0. Reset mid-ITER aborts the op and no `done` follows.
- All outputs are registered.
- Single-cycle ops: `start` accepted in cycle T, `done`=1 in T+1. `busy` stays 0 (FIN is entered at T+1 together with the `done` pulse).
- MUL, and DIV with B≠0: accepted in T; `busy`=1 in T+1…T+WIDTH; `done`=1 and `busy`=0 in T+WIDTH+1.
- `y`, `r` and the flags hold their values until the next `done`.
- Back-to-back: `start` may be asserted in the same cycle `done` is high. It is accepted and the new result overwrites the old one at its own `done`.

## Configuration
- `SEQ_ALU_MULDIV_EN` defined: MUL/DIV, the ITER state and the iteration counter are compiled in.
- `SEQ_ALU_MULDIV_EN` undefined: 01100/01101 decode as illegal opcodes (single-cycle, `y`=0, `z`=1). `busy` is tied to 0 and no iteration datapath is synthesised.

## Test plan
- ADD A=5, B=10, start at T -> `done` at T+1, `y`=15, z=n=c=v=0, `busy` never high.
- SUB A=10, B=15 -> `y`=0xFFFB, n=1, c=0, v=0; ADD 0x7FFF+1 -> `y`=0x8000, n=1, v=1, c=0; ADC 0xFFFF+0 with Ext_cin=1 -> `y`=0, z=1, c=1.
- Shifts on A=0x8001:
  - LSL -> `y`=0x0002, c=1.
  - LSR -> 0x4000, c=1.
  - ASR -> 0xC000, c=1, n=1.
  - ROR -> 0xC000, c=1.
- MUL 0x1234×0x0100 at T -> `busy` high T+1..T+16, `done` at T+17, `y`=0x3400, `r`=0x0012, c=1. With the macro undefined: `done` at T+1, `y`=0, z=1.
- DIV 100÷7 -> `y`=14, `r`=2, v=0 at T+17; DIV 0x1234÷0 -> `done` at T+1, `y`=0xFFFF, `r`=0x1234, v=1.
- `start` with new operands while `busy`=1 -> ignored, first result unchanged. `rst_n` pulsed low mid-MUL -> `busy`=0 and `y`=0 immediately, no `done` afterwards.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with start/done handshake.
// Single-cycle ops return one cycle after accept. With SEQ_ALU_MULDIV_EN
// defined, MUL/DIV iterate WIDTH cycles through a shift-add /
// restoring-divide datapath. Without it they decode as illegal.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       ALUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ext_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  localparam logic [4:0] OP_ADD = 5'b00000, OP_ADC = 5'b00001,
                         OP_SUB = 5'b00010, OP_SBC = 5'b00011,
                         OP_AND = 5'b00100, OP_OR  = 5'b00101,
                         OP_XOR = 5'b00110, OP_NOT = 5'b00111,
                         OP_LSL = 5'b01000, OP_LSR = 5'b01001,
                         OP_ASR = 5'b01010, OP_ROR = 5'b01011,
                         OP_MUL = 5'b01100, OP_DIV = 5'b01101;
  localparam int M = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] r;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
  } res_t;

  state_t           state, state_nx;
  logic             accept;
  logic             sc_iter;
  res_t             sc_res;
  logic             is_sub;
  logic             cin;
  logic [WIDTH-1:0] bo;
  logic [WIDTH:0]   sum;

`ifdef SEQ_ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0]    cnt;
  logic             last;
  logic             op_div;
  logic [WIDTH-1:0] op_m;     // multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0] p_hi;     // partial product high / running remainder
  logic [WIDTH-1:0] p_lo;     // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] st_hi, st_lo;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dsh;
  logic             dge;
`endif

  // FIN behaves like IDLE for acceptance so back-to-back starts land
  assign accept = start && (state != ITER);

  // Single-cycle result from live operands; flags MUL/DIV that must iterate
  always_comb begin
    is_sub  = (ALUop == OP_SUB) || (ALUop == OP_SBC);
    bo      = is_sub ? ~B : B;
    cin     = (ALUop == OP_ADD) ? 1'b0 : (ALUop == OP_SUB) ? 1'b1 : Ext_cin;
    sum     = {1'b0, A} + {1'b0, bo} + {{WIDTH{1'b0}}, cin};
    sc_res  = '0;
    sc_iter = 1'b0;
    case (ALUop)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        // subtract is A + ~B + cin, so carry out is the no-borrow flag and
        // overflow uses the inverted operand for both cases
        sc_res.y = sum[M:0];
        sc_res.c = sum[WIDTH];
        sc_res.v = (A[M] == bo[M]) && (sum[M] != A[M]);
      end
      OP_AND: sc_res.y = A & B;
      OP_OR:  sc_res.y = A | B;
      OP_XOR: sc_res.y = A ^ B;
      OP_NOT: sc_res.y = ~A;
      OP_LSL: begin sc_res.y = {A[M-1:0], 1'b0}; sc_res.c = A[M]; end
      OP_LSR: begin sc_res.y = {1'b0, A[M:1]};   sc_res.c = A[0]; end
      OP_ASR: begin sc_res.y = {A[M], A[M:1]};   sc_res.c = A[0]; end
      OP_ROR: begin sc_res.y = {A[0], A[M:1]};   sc_res.c = A[0]; end
`ifdef SEQ_ALU_MULDIV_EN
      OP_MUL: sc_iter = 1'b1;
      OP_DIV: begin
        if (B == '0) begin
          sc_res.y = '1;
          sc_res.r = A;
          sc_res.v = 1'b1;
        end else begin
          sc_iter = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    sc_res.z = (sc_res.y == '0);
    sc_res.n = sc_res.y[M];
  end

`ifdef SEQ_ALU_MULDIV_EN
  // One MUL shift-add or DIV restoring shift-subtract step
  always_comb begin
    msum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, op_m} : {(WIDTH+1){1'b0}});
    dsh  = {p_hi, p_lo[M]};
    dge  = (dsh >= {1'b0, op_m});
    if (op_div) begin
      st_hi = dge ? (dsh[M:0] - op_m) : dsh[M:0];
      st_lo = {p_lo[M-1:0], dge};
    end else begin
      st_hi = msum[WIDTH:1];
      st_lo = {msum[0], p_lo[M:1]};
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FIN: begin
        if (accept) state_nx = sc_iter ? ITER : FIN;
        else        state_nx = IDLE;
      end
`ifdef SEQ_ALU_MULDIV_EN
      ITER: if (last) state_nx = FIN;
`endif
      default: state_nx = IDLE;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // Result registers, handshake and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      {y, r, z, n, c, v} <= '0;
      cnt    <= '0;
      op_div <= 1'b0;
      op_m   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (sc_iter) begin
          busy   <= 1'b1;
          cnt    <= '0;
          op_div <= (ALUop == OP_DIV);
          op_m   <= (ALUop == OP_DIV) ? B : A;
          p_hi   <= '0;
          p_lo   <= (ALUop == OP_DIV) ? A : B;
        end else begin
          {y, r, z, n, c, v} <= sc_res;
          done <= 1'b1;
        end
      end else if (state == ITER) begin
        p_hi <= st_hi;
        p_lo <= st_lo;
        cnt  <= cnt + 1'b1;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
          y    <= st_lo;
          r    <= st_hi;
          z    <= (st_lo == '0);
          n    <= st_lo[M];
          c    <= !op_div && (st_hi != '0);
          v    <= 1'b0;
        end
      end
    end
  end
`else
  assign busy = 1'b0;

  // Result registers and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      {y, r, z, n, c, v} <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        {y, r, z, n, c, v} <= sc_res;
        done <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16). Follows SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  ALUop;
  logic [15:0] A, B;
  logic        Ext_cin;
  logic        busy, done;
  logic [15:0] y, r;
  logic        z, n, c, v;

  int errs = 0;
  int checks = 0;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUop(ALUop), .A(A), .B(B),
    .Ext_cin(Ext_cin), .busy(busy), .done(done), .y(y), .r(r),
    .z(z), .n(n), .c(c), .v(v)
  );

  always #5 clk = ~clk;

  // {done, busy, y, r, z, n, c, v}
  function automatic logic [37:0] obs();
    obs = {done, busy, y, r, z, n, c, v};
  endfunction

  // Drive one start pulse; returns at the negedge of cycle T+1
  task automatic issue(input logic [4:0] o, input logic [15:0] a, b, input logic ci);
    @(negedge clk);
    ALUop = o; A = a; B = b; Ext_cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] e;
    e = '0;
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL reset_state got=%h want=%h", obs(), e); end
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL reset_idle got=%h want=%h", obs(), e); end
  endtask

  task automatic test_add();
    logic [37:0] e;
    issue(5'b00000, 16'd5, 16'd10, 1'b0);
    e = {1'b1, 1'b0, 16'd15, 16'd0, 4'b0000};
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL add_done got=%h want=%h", obs(), e); end
    @(negedge clk);
    e = {1'b0, 1'b0, 16'd15, 16'd0, 4'b0000};
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL add_hold got=%h want=%h", obs(), e); end
  endtask

  task automatic test_arith();
    logic [4:0]  ops [10] = '{5'b00010, 5'b00000, 5'b00001, 5'b00011, 5'b00100,
                              5'b00110, 5'b00111, 5'b00101, 5'b00010, 5'b00011};
    logic [15:0] as  [10] = '{16'd10, 16'h7FFF, 16'hFFFF, 16'd5, 16'hF0F0,
                              16'hF0F0, 16'h0000, 16'h0000, 16'h8000, 16'd3};
    logic [15:0] bs  [10] = '{16'd15, 16'h0001, 16'h0000, 16'd3, 16'hFF00,
                              16'hFF00, 16'h1234, 16'h0000, 16'h0001, 16'd3};
    logic        cs  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] ys  [10] = '{16'hFFFB, 16'h8000, 16'h0000, 16'd1, 16'hF000,
                              16'h0FF0, 16'hFFFF, 16'h0000, 16'h7FFF, 16'd0};
    logic [3:0]  fs  [10] = '{4'b0100, 4'b0101, 4'b1010, 4'b0010, 4'b0100,
                              4'b0000, 4'b0100, 4'b1000, 4'b0011, 4'b1010};
    logic [37:0] e;
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], as[i], bs[i], cs[i]);
      e = {1'b1, 1'b0, ys[i], 16'd0, fs[i]};
      checks++;
      if (obs() !== e) begin errs++; $display("FAIL arith_%0d got=%h want=%h", i, obs(), e); end
    end
  endtask

  task automatic test_shift();
    logic [4:0]  ops [4] = '{5'b01000, 5'b01001, 5'b01010, 5'b01011};
    logic [15:0] ys  [4] = '{16'h0002, 16'h4000, 16'hC000, 16'hC000};
    logic [3:0]  fs  [4] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110};
    logic [37:0] e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 16'h8001, 16'h0000, 1'b0);
      e = {1'b1, 1'b0, ys[i], 16'd0, fs[i]};
      checks++;
      if (obs() !== e) begin errs++; $display("FAIL shift_%0d got=%h want=%h", i, obs(), e); end
    end
  endtask

  task automatic test_illegal();
    logic [37:0] e;
    issue(5'b11111, 16'h1234, 16'h5678, 1'b1);
    e = {1'b1, 1'b0, 16'd0, 16'd0, 4'b1000};
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL illegal got=%h want=%h", obs(), e); end
  endtask

  // Checks busy across T+1..T+16 then the result at T+17
  task automatic run_iter(input string nm, input logic [4:0] o, input logic [15:0] a, b,
                          input logic [37:0] e);
    int bad;
    issue(o, a, b, 1'b0);
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errs++; $display("FAIL %s_busy got=%0d bad cycles want=0", nm, bad); end
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL %s_done got=%h want=%h", nm, obs(), e); end
  endtask

  task automatic test_muldiv();
    logic [37:0] e;
`ifdef SEQ_ALU_MULDIV_EN
    run_iter("mul", 5'b01100, 16'h1234, 16'h0100, {1'b1, 1'b0, 16'h3400, 16'h0012, 4'b0010});
    run_iter("div", 5'b01101, 16'd100, 16'd7, {1'b1, 1'b0, 16'd14, 16'd2, 4'b0000});
    issue(5'b01101, 16'h1234, 16'h0000, 1'b0);
    e = {1'b1, 1'b0, 16'hFFFF, 16'h1234, 4'b0101};
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL div0 got=%h want=%h", obs(), e); end
`else
    issue(5'b01100, 16'h1234, 16'h0100, 1'b0);
    e = {1'b1, 1'b0, 16'd0, 16'd0, 4'b1000};
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL mul_off got=%h want=%h", obs(), e); end
    issue(5'b01101, 16'h1234, 16'h0000, 1'b0);
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL div_off got=%h want=%h", obs(), e); end
`endif
  endtask

  task automatic test_ignore();
`ifdef SEQ_ALU_MULDIV_EN
    logic [37:0] e;
    int extra;
    issue(5'b01100, 16'd3, 16'd5, 1'b0);   // now at T+1
    @(negedge clk);                        // T+2: busy, try to start ADD
    ALUop = 5'b00000; A = 16'd1; B = 16'd1; start = 1'b1;
    @(negedge clk);                        // T+3
    start = 1'b0;
    repeat (14) @(negedge clk);            // T+17
    e = {1'b1, 1'b0, 16'd15, 16'd0, 4'b0000};
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL ignore_result got=%h want=%h", obs(), e); end
    extra = 0;
    repeat (5) begin @(negedge clk); if (done !== 1'b0) extra++; end
    checks++;
    if (extra != 0) begin errs++; $display("FAIL ignore_nodone got=%0d want=0", extra); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [37:0] e;
    @(negedge clk);
    ALUop = 5'b00000; A = 16'd2; B = 16'd3; Ext_cin = 1'b0; start = 1'b1;
    @(negedge clk);                        // first done high; new start held
    ALUop = 5'b00010; A = 16'd9; B = 16'd4;
    e = {1'b1, 1'b0, 16'd5, 16'd0, 4'b0000};
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL b2b_first got=%h want=%h", obs(), e); end
    @(negedge clk);
    start = 1'b0;
    e = {1'b1, 1'b0, 16'd5, 16'd0, 4'b0010};
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL b2b_second got=%h want=%h", obs(), e); end
  endtask

  task automatic test_reset_mid();
    logic [37:0] e;
    int extra;
`ifdef SEQ_ALU_MULDIV_EN
    issue(5'b01100, 16'h1234, 16'h0100, 1'b0);
    repeat (4) @(negedge clk);
`endif
    #1 rst_n = 1'b0;
    #1;
    e = '0;
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL reset_mid got=%h want=%h", obs(), e); end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) extra++; end
    checks++;
    if (extra != 0) begin errs++; $display("FAIL reset_abort got=%0d want=0", extra); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ALUop = '0; A = '0; B = '0; Ext_cin = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_reset();
    test_add();
    test_arith();
    test_shift();
    test_illegal();
    test_muldiv();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
